// File: rtl/fifo_reader.sv
// Read-side controller for the request fifo: issues pops against a one-cycle registered
// read port, re-presents words through a 2-entry valid/ready buffer, and watches the wrap toggle.
module fifo_reader #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_rdata,
  input  logic                 fifo_rd_tog,
  input  logic                 fifo_error,
  output logic                 fifo_rd_en,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] pop_count,
  output logic                 err_sticky
);

  localparam int WRAP_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [WRAP_W-1:0] WRAP_LAST = WRAP_W'(FIFO_DEPTH - 1);

  logic [1:0]           r_occ;
  logic                 r_inflight;
  logic [WIDTH-1:0]     r_buf0;
  logic [WIDTH-1:0]     r_buf1;
  logic                 r_out_valid;
  logic [CNT_WIDTH-1:0] r_pop_count;
  logic [WRAP_W-1:0]    r_wrap_cnt;
  logic                 r_exp_tog;
  logic                 r_err_sticky;

  logic                 w_pop;
  logic [3:0]           w_level;
  logic [1:0]           w_tail;
  logic                 w_rd_en;
  logic                 w_tog_err;

  // Occupancy after this edge's capture and pop; a read is only issued if that leaves a free slot.
  always_comb begin
    w_pop     = r_out_valid & out_ready;
    w_level   = {2'b00, r_occ} + {3'b000, r_inflight} - {3'b000, w_pop};
    w_tail    = r_occ - {1'b0, w_pop};
    w_rd_en   = ~rst & en & ~flush & ~fifo_empty & (w_level < 4'd2);
    w_tog_err = ~r_inflight & (fifo_rd_tog != r_exp_tog);
  end

  // Occupancy, in-flight tracking and head-valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ       <= 2'd0;
      r_inflight  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_occ       <= 2'd0;
      r_inflight  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_occ       <= w_level[1:0];
      r_inflight  <= w_rd_en;
      r_out_valid <= (w_level[1:0] != 2'd0);
    end
  end

  // Buffer storage: head shifts on pop, returning word lands in the slot just past the survivors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else if (flush) begin
      r_buf0 <= r_buf0;
      r_buf1 <= r_buf1;
    end else begin
      if (w_pop && (r_occ == 2'd2)) begin
        r_buf0 <= r_buf1;
      end else begin
        r_buf0 <= r_buf0;
      end
      if (r_inflight) begin
        case (w_tail)
          2'd0:    r_buf0 <= fifo_rdata;
          2'd1:    r_buf1 <= fifo_rdata;
          default: r_buf1 <= r_buf1;
        endcase
      end else begin
        r_buf1 <= r_buf1;
      end
    end
  end

  // Read counter and wrap-toggle prediction; the fifo flips its toggle on the same read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pop_count <= '0;
      r_wrap_cnt  <= '0;
      r_exp_tog   <= 1'b0;
    end else if (w_rd_en) begin
      r_pop_count <= r_pop_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      if (r_wrap_cnt == WRAP_LAST) begin
        r_wrap_cnt <= '0;
        r_exp_tog  <= ~r_exp_tog;
      end else begin
        r_wrap_cnt <= r_wrap_cnt + {{(WRAP_W-1){1'b0}}, 1'b1};
        r_exp_tog  <= r_exp_tog;
      end
    end else begin
      r_pop_count <= r_pop_count;
      r_wrap_cnt  <= r_wrap_cnt;
      r_exp_tog   <= r_exp_tog;
    end
  end

  // Sticky error: toggle disagreement is only judged while no read is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_sticky <= 1'b0;
    end else if (fifo_error || w_tog_err) begin
      r_err_sticky <= 1'b1;
    end else begin
      r_err_sticky <= r_err_sticky;
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign out_data   = r_buf0;
  assign out_valid  = r_out_valid;
  assign pop_count  = r_pop_count;
  assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural request-fifo model (FIFO_DEPTH=4).
module tb_fifo_reader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, en, flush, fifo_empty, fifo_rd_tog, fifo_error, out_ready;
  logic [7:0]  fifo_rdata;
  logic        fifo_rd_en, out_valid, err_sticky;
  logic [7:0]  out_data;
  logic [15:0] pop_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] q[$];
  logic [7:0] rx[$];
  int   rd_total;
  int   underflow;
  bit   bad_tog;
  logic s_rd, s_valid;
  logic [7:0] s_data;

  fifo_reader #(.WIDTH(8), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_rd_tog(fifo_rd_tog), .fifo_error(fifo_error),
    .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .pop_count(pop_count), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample DUT at negedge, clock, then update the fifo model just after the edge.
  task automatic step();
    @(negedge clk);
    s_rd = fifo_rd_en; s_valid = out_valid; s_data = out_data;
    @(posedge clk);
    #1;
    if (s_rd) begin
      if (q.size() == 0) underflow++;
      else fifo_rdata = q.pop_front();
      rd_total++;
      if ((rd_total % DEPTH) == 0 && !bad_tog) fifo_rd_tog = ~fifo_rd_tog;
    end
    fifo_empty = (q.size() == 0);
  endtask

  task automatic do_reset(input bit bad);
    rst = 1'b1; en = 1'b0; flush = 1'b0; out_ready = 1'b0; fifo_error = 1'b0;
    q.delete(); rx.delete(); fifo_empty = 1'b1; fifo_rd_tog = 1'b0; fifo_rdata = 8'h00;
    rd_total = 0; underflow = 0; bad_tog = bad;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) q.push_back(base + 8'(i));
    fifo_empty = (q.size() == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_rd [6];
    logic [7:0] exp_vl [6];
    logic [7:0] exp_dt [6];
    int pulses;

    // 1: reset state, then empty fifo with en=1
    do_reset(1'b0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'h00);
    check("rst_count", 32'(pop_count), 32'd0);
    check("rst_err", 32'(err_sticky), 32'd0);
    en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_rd) pulses++;
    end
    check("empty_rd_pulses", 32'(pulses), 32'd0);
    check("empty_valid", 32'(out_valid), 32'd0);
    check("empty_count", 32'(pop_count), 32'd0);

    // 2: three words streamed with out_ready=1
    do_reset(1'b0);
    load(3, 8'h11);
    q[1] = 8'h22; q[2] = 8'h33;
    en = 1'b1; out_ready = 1'b1;
    exp_rd = '{8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0};
    exp_vl = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0};
    exp_dt = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("s2_rd_c%0d", c), 32'(s_rd), 32'(exp_rd[c]));
      check($sformatf("s2_valid_c%0d", c), 32'(s_valid), 32'(exp_vl[c]));
      if (c >= 2 && c <= 4) check($sformatf("s2_data_c%0d", c), 32'(s_data), 32'(exp_dt[c]));
    end
    check("s2_count", 32'(pop_count), 32'd3);

    // 3: backpressure, then drain five words in order
    do_reset(1'b0);
    load(5, 8'hA0);
    en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_rd) pulses++;
    end
    check("s3_rd_pulses", 32'(pulses), 32'd2);
    check("s3_count_held", 32'(pop_count), 32'd2);
    check("s3_valid_held", 32'(out_valid), 32'd1);
    check("s3_data_held", 32'(out_data), 32'hA0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_valid) rx.push_back(s_data);
    end
    check("s3_rx_count", 32'(rx.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("s3_rx%0d", i), (i < rx.size()) ? 32'(rx[i]) : 32'hDEAD, 32'hA0 + 32'(i));
    check("s3_underflow", 32'(underflow), 32'd0);
    check("s3_count", 32'(pop_count), 32'd5);
    check("s3_err", 32'(err_sticky), 32'd0);

    // 4: wrap toggle correct, then stuck at 0
    do_reset(1'b0);
    load(6, 8'h40);
    en = 1'b1; out_ready = 1'b1;
    repeat (12) step();
    check("s4_good_count", 32'(pop_count), 32'd6);
    check("s4_good_err", 32'(err_sticky), 32'd0);
    do_reset(1'b1);
    load(6, 8'h40);
    en = 1'b1; out_ready = 1'b1;
    repeat (12) step();
    check("s4_bad_err", 32'(err_sticky), 32'd1);

    // 5: flush at occ=2, then fifo_error stickiness
    do_reset(1'b0);
    load(3, 8'h70);
    en = 1'b1;
    repeat (5) step();
    check("s5_full_valid", 32'(out_valid), 32'd1);
    check("s5_full_data", 32'(out_data), 32'h70);
    flush = 1'b1; out_ready = 1'b1;
    step();
    check("s5_flush_rd", 32'(s_rd), 32'd0);
    check("s5_flush_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;
    step();
    check("s5_post_rd", 32'(s_rd), 32'd1);
    step();
    step();
    check("s5_post_valid", 32'(s_valid), 32'd1);
    check("s5_post_data", 32'(s_data), 32'h72);
    check("s5_count", 32'(pop_count), 32'd3);
    check("s5_err_clean", 32'(err_sticky), 32'd0);
    fifo_error = 1'b1;
    step();
    fifo_error = 1'b0;
    repeat (4) step();
    check("s5_err_sticky", 32'(err_sticky), 32'd1);
    do_reset(1'b0);
    check("s5_err_cleared", 32'(err_sticky), 32'd0);

    // 6: asynchronous reset between edges with occ=2
    load(4, 8'hC0);
    en = 1'b1;
    repeat (5) step();
    check("s6_pre_valid", 32'(out_valid), 32'd1);
    check("s6_pre_count", 32'(pop_count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("s6_rst_valid", 32'(out_valid), 32'd0);
    check("s6_rst_count", 32'(pop_count), 32'd0);
    check("s6_rst_rd", 32'(fifo_rd_en), 32'd0);
    step();
    check("s6_rst_rd_held", 32'(s_rd), 32'd0);
    rst = 1'b0;
    step();
    check("s6_release_rd", 32'(s_rd), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
